// File: rtl/matrix_coprocessor.sv
// 5x5 signed 8-bit matrix engine: elementwise ops, product, transpose, and a pipelined Laplace determinant.
// Optional build macro MATRIX_COPROC_SATURATE_EN clamps out-of-range elements instead of wrapping.

module matrix_coproc_sat #(
    parameter int W = 19
) (
    input  logic signed [W-1:0] val,
    output logic [7:0]          q,
    output logic                ovf
);
    // in range iff every bit above bit 7 matches the sign bit
    assign ovf = !((&val[W-1:7]) || !(|val[W-1:7]));
`ifdef MATRIX_COPROC_SATURATE_EN
    assign q = ovf ? (val[W-1] ? 8'h80 : 8'h7f) : val[7:0];
`else
    assign q = val[7:0];
`endif
endmodule

module matrix_coprocessor #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  op_code,
    input  logic [DIM*DIM*ELEM_W-1:0]   matrix_a,
    input  logic [DIM*DIM*ELEM_W-1:0]   matrix_b,
    input  logic [ELEM_W-1:0]           scalar,
    input  logic                        start,
    output logic [DIM*DIM*ELEM_W-1:0]   result_final,
    output logic                        overflow
);
    localparam int NEL = DIM * DIM;

    typedef enum logic [2:0] {IDLE, M2, M3, M4, DET, DONE} state_t;

    // Index of column pair {i,j} (unordered) within the 10 pairs of 5 columns.
    function automatic int pidx(input int i, input int j);
        int lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * (9 - lo) / 2 + (hi - lo - 1);
    endfunction

    // Position of the n-th set bit of a 5-bit column mask.
    function automatic int nth(input int mask, input int n);
        int cnt, pos;
        cnt = 0;
        pos = 0;
        for (int i = 0; i < 5; i++) begin
            if (((mask >> i) & 1) == 1) begin
                if (cnt == n) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    state_t state, state_nx;
    logic   load_ops, load_det;

    logic signed [ELEM_W-1:0] a_el [NEL];
    logic signed [ELEM_W-1:0] b_el [NEL];
    logic signed [ELEM_W-1:0] s_sc;

    logic [NEL-1:0][ELEM_W-1:0] elem_q;
    logic [NEL-1:0]             elem_ovf;

    // m2 indexed by column pair; m3 indexed by the excluded column pair; m4 by excluded column
    logic signed [16:0] m2_d [10];
    logic signed [16:0] m2_q [10];
    logic signed [26:0] m3_d [10];
    logic signed [26:0] m3_q [10];
    logic signed [36:0] m4_d [5];
    logic signed [36:0] m4_q [5];
    logic signed [47:0] det_d;
    logic [7:0]         det_q;
    logic               det_ovf;

    assign s_sc = scalar;

    for (genvar k = 0; k < NEL; k++) begin : g_unpack
        assign a_el[k] = matrix_a[ELEM_W*k +: ELEM_W];
        assign b_el[k] = matrix_b[ELEM_W*k +: ELEM_W];
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            localparam int E = DIM * r + c;
            logic signed [18:0] val, dot;

            always_comb begin
                val = '0;
                dot = '0;
                for (int k = 0; k < DIM; k++)
                    dot = dot + 19'(a_el[DIM*r+k]) * 19'(b_el[DIM*k+c]);
                case (op_code)
                    3'b000:  val = 19'(a_el[E]) + 19'(b_el[E]);
                    3'b001:  val = 19'(a_el[E]) - 19'(b_el[E]);
                    3'b010:  val = dot;
                    3'b011:  val = 19'(s_sc) * 19'(a_el[E]);
                    3'b100:  val = 19'(a_el[DIM*c+r]);
                    3'b101:  val = -19'(a_el[E]);
                    default: val = '0;
                endcase
            end

            matrix_coproc_sat #(.W(19)) u_sat (.val(val), .q(elem_q[E]), .ovf(elem_ovf[E]));
        end
    end

    for (genvar x = 0; x < 5; x++) begin : g_px
        for (genvar y = x + 1; y < 5; y++) begin : g_py
            localparam int P  = pidx(x, y);
            localparam int MK = 31 & ~((1 << x) | (1 << y));
            localparam int C0 = nth(MK, 0);
            localparam int C1 = nth(MK, 1);
            localparam int C2 = nth(MK, 2);
            assign m2_d[P] = 17'(a_el[15+x]) * 17'(a_el[20+y]) - 17'(a_el[15+y]) * 17'(a_el[20+x]);
            // 3x3 minor on the columns NOT in {x,y}, expanded along row 2
            assign m3_d[P] = 27'(a_el[10+C0]) * 27'(m2_q[pidx(C1, C2)])
                           - 27'(a_el[10+C1]) * 27'(m2_q[pidx(C0, C2)])
                           + 27'(a_el[10+C2]) * 27'(m2_q[pidx(C0, C1)]);
        end
    end

    for (genvar e = 0; e < 5; e++) begin : g_m4
        localparam int MK = 31 & ~(1 << e);
        localparam int D0 = nth(MK, 0);
        localparam int D1 = nth(MK, 1);
        localparam int D2 = nth(MK, 2);
        localparam int D3 = nth(MK, 3);
        assign m4_d[e] = 37'(a_el[5+D0]) * 37'(m3_q[pidx(e, D0)])
                       - 37'(a_el[5+D1]) * 37'(m3_q[pidx(e, D1)])
                       + 37'(a_el[5+D2]) * 37'(m3_q[pidx(e, D2)])
                       - 37'(a_el[5+D3]) * 37'(m3_q[pidx(e, D3)]);
    end

    assign det_d = 48'(a_el[0]) * 48'(m4_q[0]) - 48'(a_el[1]) * 48'(m4_q[1])
                 + 48'(a_el[2]) * 48'(m4_q[2]) - 48'(a_el[3]) * 48'(m4_q[3])
                 + 48'(a_el[4]) * 48'(m4_q[4]);

    matrix_coproc_sat #(.W(48)) u_det_sat (.val(det_d), .q(det_q), .ovf(det_ovf));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // dropping start anywhere before DONE abandons the determinant
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (op_code == 3'b110 && start) state_nx = M2;
            M2:      state_nx = start ? M3  : IDLE;
            M3:      state_nx = start ? M4  : IDLE;
            M4:      state_nx = start ? DET : IDLE;
            DET:     state_nx = start ? DONE : IDLE;
            DONE:    state_nx = start ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load_ops = 1'b0;
        load_det = 1'b0;
        if (state == IDLE && op_code != 3'b110) load_ops = 1'b1;
        if (state == DET && start)              load_det = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m2_q <= '{default: '0};
            m3_q <= '{default: '0};
            m4_q <= '{default: '0};
        end else begin
            if (state == M2) m2_q <= m2_d;
            if (state == M3) m3_q <= m3_d;
            if (state == M4) m4_q <= m4_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            result_final <= '0;
            overflow     <= 1'b0;
        end else if (load_ops) begin
            result_final <= elem_q;
            overflow     <= |elem_ovf;
        end else if (load_det) begin
            result_final <= {{((NEL-1)*ELEM_W){1'b0}}, det_q};
            overflow     <= det_ovf;
        end
    end
endmodule

// File: tb/tb_matrix_coprocessor.sv
// Directed + randomized bench for matrix_coprocessor against a Leibniz/plain-arithmetic reference model.
// Expected values follow MATRIX_COPROC_SATURATE_EN when that macro is defined.

module tb_matrix_coprocessor;
    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   op_code;
    logic [199:0] matrix_a, matrix_b;
    logic [7:0]   scalar;
    logic         start;
    logic [199:0] result_final;
    logic         overflow;

    int           A [25];
    int           B [25];
    int           S;
    logic [199:0] exp_r;
    logic         exp_o;
    int           checks = 0;
    int           failures = 0;

    matrix_coprocessor #(.ELEM_W(8), .DIM(5)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .scalar(scalar), .start(start), .result_final(result_final), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op);
        op_code = 3'(op);
        for (int k = 0; k < 25; k++) begin
            matrix_a[8*k +: 8] = 8'(A[k]);
            matrix_b[8*k +: 8] = 8'(B[k]);
        end
        scalar = 8'(S);
    endtask

    function automatic logic [7:0] fit(input longint v);
`ifdef MATRIX_COPROC_SATURATE_EN
        if (v > 127)  return 8'h7f;
        if (v < -128) return 8'h80;
`endif
        return 8'(v);
    endfunction

    // Leibniz permutation sum over all 120 permutations
    function automatic longint det5();
        longint d, prod;
        int     q, used, inv;
        int     perm [5];
        bit     ok;
        d = 0;
        for (int p = 0; p < 3125; p++) begin
            q = p; used = 0; ok = 1'b1; inv = 0; prod = 1;
            for (int i = 0; i < 5; i++) begin
                perm[i] = q % 5;
                q = q / 5;
                if (((used >> perm[i]) & 1) == 1) ok = 1'b0;
                used = used | (1 << perm[i]);
            end
            if (ok) begin
                for (int i = 0; i < 5; i++)
                    for (int j = i + 1; j < 5; j++)
                        if (perm[i] > perm[j]) inv++;
                for (int i = 0; i < 5; i++) prod = prod * A[5*i+perm[i]];
                d = (inv % 2 == 1) ? d - prod : d + prod;
            end
        end
        return d;
    endfunction

    task automatic model(input int op);
        longint v, d;
        int     r, c;
        bit     o;
        exp_r = '0;
        o = 1'b0;
        d = 0;
        if (op == 6) d = det5();
        for (int k = 0; k < 25; k++) begin
            r = k / 5;
            c = k % 5;
            case (op)
                0: v = A[k] + B[k];
                1: v = A[k] - B[k];
                2: begin
                    v = 0;
                    for (int i = 0; i < 5; i++) v = v + longint'(A[5*r+i]) * B[5*i+c];
                end
                3: v = longint'(S) * A[k];
                4: v = A[5*c+r];
                5: v = -A[k];
                6: v = (k == 0) ? d : 0;
                default: v = 0;
            endcase
            exp_r[8*k +: 8] = fit(v);
            if (v > 127 || v < -128) o = 1'b1;
        end
        exp_o = o;
    endtask

    task automatic check(input string tag);
        checks++;
        assert (result_final === exp_r) else begin
            failures++;
            $error("FAIL %s result got=%h exp=%h", tag, result_final, exp_r);
        end
        checks++;
        assert (overflow === exp_o) else begin
            failures++;
            $error("FAIL %s overflow got=%b exp=%b", tag, overflow, exp_o);
        end
    endtask

    task automatic check_elem(input string tag, input int k, input int e);
        logic [7:0] want, got;
        want = 8'(e);
        got  = result_final[8*k +: 8];
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s elem%0d got=%0d exp=%0d", tag, k, $signed(got), $signed(want));
        end
    endtask

    task automatic run_det(input string tag);
        drive(6);
        start = 1'b1;
        repeat (4) step();
        check({tag, "_hold"});
        step();
        model(6);
        check(tag);
        step();
        check({tag, "_done"});
        start = 1'b0;
        step();
        check({tag, "_idle"});
    endtask

    task automatic rand_mat(input int lo, input int hi);
        for (int k = 0; k < 25; k++) begin
            A[k] = int'($urandom_range(0, hi - lo)) + lo;
            B[k] = int'($urandom_range(0, hi - lo)) + lo;
        end
        S = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        int op;
        rst = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin A[k] = k + 1; B[k] = 1; end
        S = 3;
        drive(0);
        step();
        exp_r = '0; exp_o = 1'b0;
        check("reset");
        step();
        check("reset2");
        rst = 1'b1;

        drive(0); step(); model(0); check("add"); check_elem("add", 24, 26);
        drive(1); step(); model(1); check("sub"); check_elem("sub", 7, 7);
        drive(2); step(); model(2); check("mul");
        check_elem("mul_r0", 0, 15); check_elem("mul_r1", 5, 40); check_elem("mul_r4", 24, 115);
        drive(3); step(); model(3); check("scal3"); check_elem("scal3", 24, 75);
        S = 8;
        drive(3); step(); model(3); check("scal8");
`ifdef MATRIX_COPROC_SATURATE_EN
        check_elem("scal8", 24, 127);
`else
        check_elem("scal8", 24, -56);
`endif
        drive(4); step(); model(4); check("trans");
        check_elem("trans1", 1, 6); check_elem("trans5", 5, 2);
        A[0] = -128;
        drive(5); step(); model(5); check("neg");
`ifdef MATRIX_COPROC_SATURATE_EN
        check_elem("neg128", 0, 127);
`else
        check_elem("neg128", 0, -128);
`endif
        drive(7); step(); model(7); check("reserved");

        for (int k = 0; k < 25; k++) A[k] = k + 1;
        drive(0); step(); model(0); check("pre_det");
        run_det("det_seq");
        check_elem("det_seq", 0, 0);
        for (int k = 0; k < 25; k++) A[k] = (k % 6 == 0) ? 2 : 0;
        run_det("det_2i");
        check_elem("det_2i", 0, 32);
        for (int k = 0; k < 25; k++) A[k] = (k % 6 == 0) ? 3 : 0;
        run_det("det_3i");
`ifndef MATRIX_COPROC_SATURATE_EN
        check_elem("det_3i", 0, -13);
`endif
        for (int t = 0; t < 4; t++) begin rand_mat(-3, 3); run_det("det_small"); end
        for (int t = 0; t < 2; t++) begin rand_mat(-128, 127); run_det("det_full"); end

        for (int t = 0; t < 40; t++) begin
            if (t % 2 == 0) rand_mat(-128, 127);
            else            rand_mat(-6, 6);
            op = int'($urandom_range(0, 6));
            if (op == 6) op = 7;
            drive(op); step(); model(op); check("rand_op");
        end

        // reset while the determinant sits in M3
        rand_mat(-128, 127);
        drive(0); step(); model(0); check("pre_rst");
        drive(6); start = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        exp_r = '0; exp_o = 1'b0;
        check("rst_mid");
        rst = 1'b1; start = 1'b0;
        rand_mat(-20, 20);
        drive(0); step(); model(0); check("post_rst");

        // drop start while in M4
        drive(6); start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        step();
        check("abort");
        repeat (3) step();
        check("abort_hold");
        drive(1); step(); model(1); check("post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
